// File: rtl/sdram_cmd_seq_if.sv
// Opcode/idle handshake from the main control unit plus the SDRAM pin and data-path strobe bundle.
interface sdram_cmd_seq_if #(
    parameter int ROW_BITS  = 12,
    parameter int COL_BITS  = 8,
    parameter int BANK_BITS = 2
);
    logic [2:0]                            opcode;
    logic [BANK_BITS+ROW_BITS+COL_BITS-1:0] addr;
    logic                                  idle;
    logic [3:0]                            sd_cmd;
    logic [ROW_BITS-1:0]                   sd_addr;
    logic [BANK_BITS-1:0]                  sd_ba;
    logic                                  sd_cke;
    logic                                  wdata_strobe;
    logic                                  rdata_valid;

    modport master (
        output opcode, addr,
        input  idle, sd_cmd, sd_addr, sd_ba, sd_cke, wdata_strobe, rdata_valid
    );
    modport slave (
        input  opcode, addr,
        output idle, sd_cmd, sd_addr, sd_ba, sd_cke, wdata_strobe, rdata_valid
    );
endinterface

// File: rtl/sdram_cmd_seq.sv
// Expands control-unit opcodes into timed SDRAM command sequences: init, refresh,
// self-refresh and single/burst auto-precharge reads and writes.
module sdram_cmd_seq #(
    parameter int ROW_BITS  = 12,
    parameter int COL_BITS  = 8,
    parameter int BANK_BITS = 2,
    parameter int BURST_LEN = 8,
    parameter int CAS_LAT   = 2,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 7,
    parameter int T_WR      = 2,
    parameter int T_XSR     = 8,
    parameter int INIT_WAIT = 100
) (
    input logic           clk,
    input logic           rst,
    sdram_cmd_seq_if.slave bus
);
    localparam int ADDR_W = BANK_BITS + ROW_BITS + COL_BITS;
    localparam int CNT_W  = $clog2(INIT_WAIT + T_RFC + T_XSR + T_WR + T_RP + CAS_LAT + T_RCD + 2);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    localparam logic [ROW_BITS-1:0] A10_BIT  = ROW_BITS'(1024);
    localparam logic [ROW_BITS-1:0] MODE_REG = ROW_BITS'(CAS_LAT << 4);

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
        S_IDLE, S_SR, S_SR_EXIT, S_COL, S_DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [BEAT_W-1:0]    beats;
    logic [COL_BITS-1:0]  col_r;
    logic [2:0]           op_r;
    logic [ADDR_W-1:0]    addr_r;
    logic                 pending;
    logic                 is_wr;
    logic [CAS_LAT:0]     rd_pipe;

    logic [2:0]           seq_op;
    logic [ADDR_W-1:0]    seq_addr;
    logic                 start;
    logic [ROW_BITS-1:0]  col_addr;

    // A sequence launches straight from IDLE, or from a capture held over self-refresh exit
    assign seq_op   = (state == S_IDLE) ? bus.opcode : op_r;
    assign seq_addr = (state == S_IDLE) ? bus.addr   : addr_r;
    assign start    = ((state == S_IDLE) && (bus.opcode >= 3'd3)) ||
                      ((state == S_SR_EXIT) && (cnt == '0) && pending);

    always_comb begin
        col_addr                = '0;
        col_addr[COL_BITS-1:0]  = col_r;
        col_addr[10]            = (beats == BEAT_W'(1));
    end

    assign bus.rdata_valid = rd_pipe[CAS_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_INIT_WAIT;
            cnt              <= CNT_W'(INIT_WAIT);
            beats            <= '0;
            col_r            <= '0;
            op_r             <= '0;
            addr_r           <= '0;
            pending          <= 1'b0;
            is_wr            <= 1'b0;
            rd_pipe          <= '0;
            bus.sd_cmd       <= CMD_NOP;
            bus.sd_addr      <= '0;
            bus.sd_ba        <= '0;
            bus.sd_cke       <= 1'b1;
            bus.idle         <= 1'b0;
            bus.wdata_strobe <= 1'b0;
        end else begin
            bus.sd_cmd       <= CMD_NOP;
            bus.wdata_strobe <= 1'b0;
            rd_pipe          <= {rd_pipe[CAS_LAT-1:0], 1'b0};
            // Spacing counter: loaded with T-1 at a command, next command fires when it reads zero
            if (cnt != '0) cnt <= cnt - 1'b1;

            case (state)
                S_INIT_WAIT: if (cnt == '0) begin
                    bus.sd_cmd  <= CMD_PRE;
                    bus.sd_addr <= A10_BIT;
                    cnt         <= CNT_W'(T_RP - 1);
                    state       <= S_INIT_PRE;
                end
                S_INIT_PRE: if (cnt == '0) begin
                    bus.sd_cmd <= CMD_REF;
                    cnt        <= CNT_W'(T_RFC - 1);
                    state      <= S_INIT_REF1;
                end
                S_INIT_REF1: if (cnt == '0) begin
                    bus.sd_cmd <= CMD_REF;
                    cnt        <= CNT_W'(T_RFC - 1);
                    state      <= S_INIT_REF2;
                end
                S_INIT_REF2: if (cnt == '0) begin
                    bus.sd_cmd  <= CMD_LMR;
                    bus.sd_addr <= MODE_REG;
                    bus.sd_ba   <= '0;
                    cnt         <= CNT_W'(1);
                    state       <= S_INIT_MRS;
                end
                S_INIT_MRS: if (cnt == '0) begin
                    bus.idle <= 1'b1;
                    state    <= S_IDLE;
                end
                S_IDLE: if (bus.opcode == 3'd2) begin
                    bus.sd_cmd <= CMD_REF;
                    bus.sd_cke <= 1'b0;
                    state      <= S_SR;
                end
                S_SR: if (bus.opcode != 3'd2) begin
                    bus.sd_cke <= 1'b1;
                    cnt        <= CNT_W'(T_XSR - 1);
                    state      <= S_SR_EXIT;
                end
                S_SR_EXIT: begin
                    if (cnt != '0) begin
                        if (!pending && (bus.opcode >= 3'd3)) begin
                            pending  <= 1'b1;
                            op_r     <= bus.opcode;
                            addr_r   <= bus.addr;
                            bus.idle <= 1'b0;
                        end
                    end else if (!pending) begin
                        state <= S_IDLE;
                    end
                end
                S_COL: if (cnt == '0) begin
                    bus.sd_cmd       <= is_wr ? CMD_WR : CMD_RD;
                    bus.sd_addr      <= col_addr;
                    bus.wdata_strobe <= is_wr;
                    rd_pipe[0]       <= ~is_wr;
                    col_r            <= col_r + 1'b1;
                    beats            <= beats - 1'b1;
                    if (beats == BEAT_W'(1)) begin
                        cnt   <= is_wr ? CNT_W'(T_WR + T_RP - 1) : CNT_W'(CAS_LAT + T_RP - 1);
                        state <= S_DONE;
                    end
                end
                S_DONE: if (cnt == '0) begin
                    bus.idle <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_INIT_WAIT;
            endcase

            // Every access auto-precharges, so refresh needs no precharge-all first
            if (start) begin
                pending   <= 1'b0;
                bus.idle  <= 1'b0;
                col_r     <= seq_addr[COL_BITS-1:0];
                bus.sd_ba <= seq_addr[ADDR_W-1 -: BANK_BITS];
                is_wr     <= seq_op[1];
                beats     <= seq_op[0] ? BEAT_W'(BURST_LEN) : BEAT_W'(1);
                if (seq_op == 3'd3) begin
                    bus.sd_cmd <= CMD_REF;
                    cnt        <= CNT_W'(T_RFC - 1);
                    state      <= S_DONE;
                end else begin
                    bus.sd_cmd  <= CMD_ACT;
                    bus.sd_addr <= seq_addr[COL_BITS +: ROW_BITS];
                    cnt         <= CNT_W'(T_RCD - 1);
                    state       <= S_COL;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_cmd_seq.sv
// Randomized and directed bench for sdram_cmd_seq against an event-time reference model.
module tb_sdram_cmd_seq;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;
    localparam int BURST_LEN = 8, CAS_LAT = 2, T_RCD = 2, T_RP = 2, T_RFC = 7;
    localparam int T_WR = 2, T_XSR = 8, INIT_WAIT = 100;
    localparam int IDLE_AT = INIT_WAIT + T_RP + 2 * T_RFC + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_cmd_seq_if sif();
    sdram_cmd_seq dut (.clk(clk), .rst(rst), .bus(sif));

    int passed = 0;
    int total  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] obs();
        return {sif.sd_cmd, sif.idle, sif.wdata_strobe, sif.rdata_valid, sif.sd_cke};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        sif.opcode = 3'd4;
        sif.addr = 22'($urandom);
        repeat (3) tick();
        total++;
        if (obs() !== {NOP, 4'b0001}) $display("FAIL reset_ctrl: got %h want %h", obs(), {NOP, 4'b0001});
        else passed++;
        total++;
        if ({sif.sd_addr, sif.sd_ba} !== 14'd0) $display("FAIL reset_addr: got %h want 0", {sif.sd_addr, sif.sd_ba});
        else passed++;
    endtask

    task automatic test_init(input string tag);
        logic [3:0] ec;
        logic [7:0] e;
        rst = 1'b0;
        for (int k = 0; k <= IDLE_AT; k++) begin
            tick();
            ec = NOP;
            if (k == INIT_WAIT) ec = PRE;
            else if (k == INIT_WAIT + T_RP || k == INIT_WAIT + T_RP + T_RFC) ec = REF;
            else if (k == INIT_WAIT + T_RP + 2 * T_RFC) ec = LMR;
            e = {ec, (k == IDLE_AT), 3'b001};
            total++;
            if (obs() !== e) $display("FAIL %s_init cyc %0d: got %h want %h", tag, k, obs(), e);
            else passed++;
            if (ec == PRE) begin
                total++;
                if (sif.sd_addr[10] !== 1'b1) $display("FAIL %s_pre_a10: got %b want 1", tag, sif.sd_addr[10]);
                else passed++;
            end
            if (ec == LMR) begin
                total++;
                if ({sif.sd_addr, sif.sd_ba} !== {12'h020, 2'd0})
                    $display("FAIL %s_mode: got %h want %h", tag, {sif.sd_addr, sif.sd_ba}, {12'h020, 2'd0});
                else passed++;
            end
            sif.opcode = (k == IDLE_AT) ? 3'd0 : 3'($urandom_range(0, 7));
        end
    endtask

    task automatic test_single_read();
        logic [3:0] ec;
        logic [7:0] e;
        sif.opcode = 3'd4;
        sif.addr = {2'd1, 12'h123, 8'h45};
        for (int j = 1; j <= 7; j++) begin
            tick();
            ec = (j == 1) ? ACT : (j == 3) ? RD : NOP;
            e = {ec, (j == 7), 1'b0, (j == 5), 1'b1};
            total++;
            if (obs() !== e) $display("FAIL single_read cyc %0d: got %h want %h", j, obs(), e);
            else passed++;
            if (j == 1) begin
                total++;
                if ({sif.sd_ba, sif.sd_addr} !== {2'd1, 12'h123})
                    $display("FAIL single_read_act: got %h want %h", {sif.sd_ba, sif.sd_addr}, {2'd1, 12'h123});
                else passed++;
            end
            if (j == 3) begin
                total++;
                if ({sif.sd_ba, sif.sd_addr} !== {2'd1, 12'h445})
                    $display("FAIL single_read_col: got %h want %h", {sif.sd_ba, sif.sd_addr}, {2'd1, 12'h445});
                else passed++;
            end
            sif.opcode = (j == 7) ? 3'd0 : 3'($urandom_range(0, 7));
            sif.addr = 22'($urandom);
        end
    endtask

    task automatic test_burst_write_wrap();
        logic [1:0] b;
        logic [11:0] r, ea;
        logic [3:0] ec;
        logic [7:0] e;
        logic wr_cyc;
        b = 2'($urandom_range(0, 3));
        r = 12'($urandom);
        sif.opcode = 3'd7;
        sif.addr = {b, r, 8'hFE};
        for (int j = 1; j <= 14; j++) begin
            tick();
            wr_cyc = (j >= 3 && j <= 10);
            ec = (j == 1) ? ACT : wr_cyc ? WR : NOP;
            e = {ec, (j == 14), wr_cyc, 1'b0, 1'b1};
            total++;
            if (obs() !== e) $display("FAIL burst_wr cyc %0d: got %h want %h", j, obs(), e);
            else passed++;
            if (j == 1) begin
                total++;
                if ({sif.sd_ba, sif.sd_addr} !== {b, r})
                    $display("FAIL burst_wr_act: got %h want %h", {sif.sd_ba, sif.sd_addr}, {b, r});
                else passed++;
            end
            if (wr_cyc) begin
                ea = 12'((254 + j - 3) % 256) | ((j == 10) ? 12'h400 : 12'h000);
                total++;
                if ({sif.sd_ba, sif.sd_addr} !== {b, ea})
                    $display("FAIL burst_wr_col cyc %0d: got %h want %h", j, {sif.sd_ba, sif.sd_addr}, {b, ea});
                else passed++;
            end
            sif.opcode = (j == 14) ? 3'd0 : 3'($urandom_range(0, 7));
            sif.addr = 22'($urandom);
        end
    endtask

    task automatic test_auto_refresh();
        logic [7:0] e;
        sif.opcode = 3'd3;
        for (int j = 1; j <= 1 + T_RFC; j++) begin
            tick();
            e = {(j == 1) ? REF : NOP, (j == 1 + T_RFC), 3'b001};
            total++;
            if (obs() !== e) $display("FAIL auto_ref cyc %0d: got %h want %h", j, obs(), e);
            else passed++;
            sif.opcode = (j == 1 + T_RFC) ? 3'd0 : 3'($urandom_range(0, 7));
        end
    endtask

    task automatic test_self_refresh();
        logic [1:0] b;
        logic [11:0] r;
        logic [7:0] c;
        logic [3:0] ec;
        logic [7:0] e;
        int n;
        sif.opcode = 3'd2;
        tick();
        total++;
        if (obs() !== {REF, 4'b1000}) $display("FAIL sr_entry: got %h want %h", obs(), {REF, 4'b1000});
        else passed++;
        n = $urandom_range(3, 10);
        for (int i = 0; i < n; i++) begin
            tick();
            total++;
            if (obs() !== {NOP, 4'b1000}) $display("FAIL sr_hold %0d: got %h want %h", i, obs(), {NOP, 4'b1000});
            else passed++;
        end
        sif.opcode = 3'd0;
        b = 2'($urandom_range(0, 3));
        r = 12'($urandom);
        c = 8'($urandom);
        for (int j = 1; j <= 15; j++) begin
            tick();
            ec = (j == 1 + T_XSR) ? ACT : (j == 1 + T_XSR + T_RCD) ? RD : NOP;
            e = {ec, (j <= 2 || j == 15), 1'b0, (j == 13), 1'b1};
            total++;
            if (obs() !== e) $display("FAIL sr_exit cyc %0d: got %h want %h", j, obs(), e);
            else passed++;
            if (ec == ACT) begin
                total++;
                if ({sif.sd_ba, sif.sd_addr} !== {b, r})
                    $display("FAIL sr_pending_act: got %h want %h", {sif.sd_ba, sif.sd_addr}, {b, r});
                else passed++;
            end
            if (ec == RD) begin
                total++;
                if ({sif.sd_ba, sif.sd_addr} !== {b, 4'h4, c})
                    $display("FAIL sr_pending_rd: got %h want %h", {sif.sd_ba, sif.sd_addr}, {b, 4'h4, c});
                else passed++;
            end
            if (j == 1) sif.opcode = 3'd0;
            else if (j == 2) begin
                sif.opcode = 3'd4;
                sif.addr = {b, r, c};
            end else if (j == 15) sif.opcode = 3'd0;
            else begin
                sif.opcode = 3'($urandom_range(0, 7));
                sif.addr = 22'($urandom);
            end
        end
    endtask

    task automatic test_random_access();
        logic [3:0] exp_cmd [0:31];
        logic [13:0] exp_loc [0:31];
        logic exp_ws [0:31];
        logic exp_rv [0:31];
        logic [2:0] op;
        logic [1:0] b;
        logic [11:0] r;
        logic [7:0] c;
        logic [7:0] e;
        int n, s, end_c, gap;
        for (int it = 0; it < 25; it++) begin
            op = 3'($urandom_range(3, 7));
            b = 2'($urandom_range(0, 3));
            r = 12'($urandom);
            c = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom);
            for (int k = 0; k < 32; k++) begin
                exp_cmd[k] = NOP; exp_loc[k] = '0; exp_ws[k] = 1'b0; exp_rv[k] = 1'b0;
            end
            if (op == 3'd3) begin
                exp_cmd[1] = REF;
                end_c = 1 + T_RFC;
            end else begin
                n = op[0] ? BURST_LEN : 1;
                exp_cmd[1] = ACT;
                exp_loc[1] = {b, r};
                for (int i = 0; i < n; i++) begin
                    s = 1 + T_RCD + i;
                    exp_cmd[s] = op[1] ? WR : RD;
                    exp_loc[s] = {b, 12'((c + i) % 256) | ((i == n - 1) ? 12'h400 : 12'h000)};
                    if (op[1]) exp_ws[s] = 1'b1;
                    else exp_rv[s + CAS_LAT] = 1'b1;
                end
                end_c = 1 + T_RCD + n - 1 + (op[1] ? T_WR + T_RP : CAS_LAT + T_RP);
            end
            sif.opcode = op;
            sif.addr = {b, r, c};
            for (int j = 1; j <= end_c; j++) begin
                tick();
                e = {exp_cmd[j], (j == end_c), exp_ws[j], exp_rv[j], 1'b1};
                total++;
                if (obs() !== e) $display("FAIL rand op%0d cyc %0d: got %h want %h", op, j, obs(), e);
                else passed++;
                if (exp_cmd[j] == ACT || exp_cmd[j] == RD || exp_cmd[j] == WR) begin
                    total++;
                    if ({sif.sd_ba, sif.sd_addr} !== exp_loc[j])
                        $display("FAIL rand_addr op%0d cyc %0d: got %h want %h", op, j, {sif.sd_ba, sif.sd_addr}, exp_loc[j]);
                    else passed++;
                end
                sif.opcode = (j == end_c) ? 3'd0 : 3'($urandom_range(0, 7));
                sif.addr = 22'($urandom);
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                total++;
                if (obs() !== {NOP, 4'b1001}) $display("FAIL rand_gap: got %h want %h", obs(), {NOP, 4'b1001});
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] ec;
        logic [7:0] e;
        sif.opcode = 3'd5;
        sif.addr = 22'($urandom);
        for (int j = 1; j <= 5; j++) begin
            tick();
            ec = (j == 1) ? ACT : (j >= 3) ? RD : NOP;
            e = {ec, 1'b0, 1'b0, (j == 5), 1'b1};
            total++;
            if (obs() !== e) $display("FAIL mid_burst cyc %0d: got %h want %h", j, obs(), e);
            else passed++;
            sif.opcode = 3'($urandom_range(0, 7));
        end
        rst = 1'b1;
        tick();
        total++;
        if (obs() !== {NOP, 4'b0001}) $display("FAIL mid_burst_reset: got %h want %h", obs(), {NOP, 4'b0001});
        else passed++;
        test_init("rerun");
    endtask

    initial begin
        sif.opcode = 3'd0;
        sif.addr = '0;
        test_reset();
        test_init("power_up");
        test_single_read();
        test_burst_write_wrap();
        test_auto_refresh();
        test_self_refresh();
        test_random_access();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
